// File: rtl/bit_population_pkg.sv
// Sizing helpers shared by the population accumulator and its bench.
// All functions are constant-evaluable so they can size ports and generate loops.
package bit_population_pkg;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int sum_w(input int width, input int max_beats);
        return $clog2(width * max_beats + 1);
    endfunction

    function automatic int nleaf(input int width, input int leaf);
        return (width + leaf - 1) / leaf;
    endfunction

    function automatic int tree_stages(input int n_leaf);
        return $clog2(n_leaf);
    endfunction

    // Number of nodes at tree level k (level 0 = leaves).
    function automatic int lvl_n(input int n_leaf, input int k);
        return (n_leaf + (1 << k) - 1) >> k;
    endfunction

    // Tree nodes are stored flat, level by level; this returns where level k starts.
    function automatic int lvl_off(input int n_leaf, input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) o += lvl_n(n_leaf, j);
        return o;
    endfunction

    // Beat counter saturates at MAX_BEATS+1.
    function automatic int beats_w(input int max_beats);
        return $clog2(max_beats + 2);
    endfunction

endpackage

// File: rtl/popcount_leaf.sv
// Combinational popcount of one LEAF-bit slice; mode inverts the bits first and
// mask removes padding bits so they count zero in either mode.
module popcount_leaf #(
    parameter int LEAF = 4,
    parameter int CW   = $clog2(LEAF + 1)
) (
    input  logic [LEAF-1:0] bits,
    input  logic [LEAF-1:0] mask,
    input  logic            mode,
    output logic [CW-1:0]   cnt
);

    always_comb begin
        cnt = '0;
        for (int j = 0; j < LEAF; j++) begin
            cnt = cnt + CW'(mask[j] & (bits[j] ^ mode));
        end
    end

endmodule

// File: rtl/bit_population_accumulator.sv
// Pipelined per-beat popcount (leaf counters + registered adder tree) feeding a
// saturating per-frame accumulator with a valid/ready output register.
module bit_population_accumulator
    import bit_population_pkg::*;
#(
    parameter  int WIDTH     = 24,
    parameter  int LEAF      = 4,
    parameter  int MAX_BEATS = 256,
    localparam int SUM_W     = sum_w(WIDTH, MAX_BEATS)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    input  logic             data_last_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [SUM_W-1:0] total_o,
    output logic             total_ovf_o,
    output logic             total_val_o,
    input  logic             total_ready_i
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam int NLEAF = nleaf(WIDTH, LEAF);
    localparam int TS    = tree_stages(NLEAF);
    localparam int NODES = lvl_off(NLEAF, TS + 1);
    localparam int LW    = $clog2(LEAF + 1);
    localparam int PADW  = NLEAF * LEAF;
    localparam int BW    = beats_w(MAX_BEATS);
    localparam logic [PADW-1:0]  MASK = PADW'({WIDTH{1'b1}});
    localparam logic [SUM_W-1:0] SAT  = '1;

    logic                        en;
    logic [PADW-1:0]             data_pad;
    logic [NODES-1:0][CNT_W-1:0] tree_d, tree_q;
    logic [TS:0]                 vld_pipe, last_pipe;
    logic [SUM_W-1:0]            acc;
    logic [BW-1:0]               beats;
    logic [CNT_W-1:0]            cnt;
    logic [SUM_W:0]              sum_ext;
    logic [SUM_W-1:0]            sum_sat;
    logic                        over_beats;

    assign en           = !total_val_o || total_ready_i;
    assign data_ready_o = en;
    assign data_pad     = PADW'(data_i);

    for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
        logic [LW-1:0] leaf_cnt;
        popcount_leaf #(.LEAF(LEAF), .CW(LW)) u_leaf (
            .bits (data_pad[i*LEAF +: LEAF]),
            .mask (MASK[i*LEAF +: LEAF]),
            .mode (mode_i),
            .cnt  (leaf_cnt)
        );
        assign tree_d[i] = CNT_W'(leaf_cnt);
    end

    // Each level sums pairs of the previous level's registered nodes; an odd tail passes through.
    for (genvar k = 1; k <= TS; k++) begin : g_lvl
        for (genvar i = 0; i < lvl_n(NLEAF, k); i++) begin : g_node
            localparam int SRC = lvl_off(NLEAF, k - 1) + 2 * i;
            localparam int DST = lvl_off(NLEAF, k) + i;
            if (2 * i + 1 < lvl_n(NLEAF, k - 1)) begin : g_pair
                assign tree_d[DST] = tree_q[SRC] + tree_q[SRC+1];
            end else begin : g_pass
                assign tree_d[DST] = tree_q[SRC];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            tree_q       <= tree_d;
            last_pipe[0] <= data_last_i;
            for (int k = 1; k <= TS; k++) last_pipe[k] <= last_pipe[k-1];
        end
    end

    assign cnt        = tree_q[NODES-1];
    assign sum_ext    = {1'b0, acc} + (SUM_W+1)'(cnt);
    assign sum_sat    = sum_ext[SUM_W] ? SAT : sum_ext[SUM_W-1:0];
    assign over_beats = (beats >= BW'(MAX_BEATS));

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            vld_pipe    <= '0;
            acc         <= '0;
            beats       <= '0;
            total_o     <= '0;
            total_ovf_o <= 1'b0;
            total_val_o <= 1'b0;
        end else if (en) begin
            vld_pipe[0] <= data_val_i;
            for (int k = 1; k <= TS; k++) vld_pipe[k] <= vld_pipe[k-1];
            total_val_o <= 1'b0;
            if (vld_pipe[TS]) begin
                if (last_pipe[TS]) begin
                    total_o     <= sum_sat;
                    total_ovf_o <= over_beats | sum_ext[SUM_W];
                    total_val_o <= 1'b1;
                    acc         <= '0;
                    beats       <= '0;
                end else begin
                    acc <= sum_sat;
                    if (beats != BW'(MAX_BEATS + 1)) beats <= beats + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_population_accumulator.sv
// Self-checking bench: directed frames plus random traffic against a frame-level model.
module tb_bit_population_accumulator;
    import bit_population_pkg::*;

    localparam int WIDTH = 24;
    localparam int LEAF  = 4;
    localparam int MAXB  = 4;
    localparam int SUM_W = sum_w(WIDTH, MAXB);
    localparam int SATV  = (1 << SUM_W) - 1;

    logic             clk = 1'b0;
    logic             srst_i;
    logic [WIDTH-1:0] data_i;
    logic             mode_i, data_last_i, data_val_i, data_ready_o;
    logic [SUM_W-1:0] total_o;
    logic             total_ovf_o, total_val_o, total_ready_i;

    always #5 clk = ~clk;

    bit_population_accumulator #(.WIDTH(WIDTH), .LEAF(LEAF), .MAX_BEATS(MAXB)) dut (
        .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .mode_i(mode_i),
        .data_last_i(data_last_i), .data_val_i(data_val_i), .data_ready_o(data_ready_o),
        .total_o(total_o), .total_ovf_o(total_ovf_o), .total_val_o(total_val_o),
        .total_ready_i(total_ready_i)
    );

    typedef struct { int total; int ovf; } res_t;
    typedef struct { logic [WIDTH-1:0] d; logic m; int exp_total; } vec_t;

    int   checks = 0, fails = 0, cyc = 0;
    res_t exp_q[$];
    int   got_q[$];
    int   got_ovf_q[$];
    int   m_acc = 0, m_nb = 0;
    bit   hold = 0;
    logic [SUM_W-1:0] h_total;
    logic h_ovf;
    int   last_acc_cyc = 0, last_pop_cyc = 0;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, then score output handshake and input acceptance.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic m,
                        input logic l, input logic r, output bit accepted);
        @(negedge clk);
        data_val_i = v; data_i = d; mode_i = m; data_last_i = l; total_ready_i = r;
        #1;
        cyc++;
        chk("ready_eq", data_ready_o, !total_val_o || total_ready_i);
        if (hold) begin
            chk("hold_val", total_val_o, 1);
            chk("hold_total", total_o, h_total);
            chk("hold_ovf", total_ovf_o, h_ovf);
        end
        hold = total_val_o && !total_ready_i;
        h_total = total_o;
        h_ovf = total_ovf_o;
        if (total_val_o && total_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_total: got %0d expected none", total_o);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("total", total_o, e.total);
                chk("ovf", total_ovf_o, e.ovf);
            end
            got_q.push_back(int'(total_o));
            got_ovf_q.push_back(int'(total_ovf_o));
            last_pop_cyc = cyc;
        end
        accepted = v && data_ready_o;
        if (accepted) begin
            int c;
            c = $countones(d);
            if (m) c = WIDTH - c;
            m_acc += c;
            m_nb++;
            if (l) begin
                res_t e;
                e.total = (m_acc > SATV) ? SATV : m_acc;
                e.ovf = (m_nb > MAXB) ? 1 : 0;
                exp_q.push_back(e);
                m_acc = 0;
                m_nb = 0;
                last_acc_cyc = cyc;
            end
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic m, input logic l);
        bit a;
        int n;
        a = 0;
        n = 0;
        while (!a && n < 50) begin
            step(1'b1, d, m, l, 1'b1, a);
            n++;
        end
        if (!a) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input int bound);
        bit a;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (7) step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst_i = 1'b1;
        data_val_i = 1'b0;
        total_ready_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_val", total_val_o, 0);
        chk("rst_total", total_o, 0);
        chk("rst_ovf", total_ovf_o, 0);
        chk("rst_ready", data_ready_o, 1);
        srst_i = 1'b0;
        exp_q.delete();
        m_acc = 0;
        m_nb = 0;
        hold = 0;
    endtask

    initial begin
        bit a;
        int idx;
        bit saw_low;
        logic [WIDTH-1:0] dv;

        tbl[0] = '{24'hFFFFFF, 1'b0, 24};
        tbl[1] = '{24'h000000, 1'b1, 24};
        tbl[2] = '{24'h000000, 1'b0, 0};
        tbl[3] = '{24'hFFFFFF, 1'b1, 0};
        tbl[4] = '{24'hA5A5A5, 1'b0, 12};
        tbl[5] = '{24'h800001, 1'b1, 22};
        tbl[6] = '{24'h0F0F0F, 1'b1, 12};
        tbl[7] = '{24'h123456, 1'b0, 9};

        srst_i = 1'b1; data_i = '0; mode_i = 0; data_last_i = 0; data_val_i = 0; total_ready_i = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("init_val", total_val_o, 0);
        chk("init_total", total_o, 0);
        chk("init_ovf", total_ovf_o, 0);
        chk("init_ready", data_ready_o, 1);
        srst_i = 1'b0;

        // single all-ones beat: value and latency
        got_q.delete();
        send(24'hFFFFFF, 1'b0, 1'b1);
        drain(20);
        chk("t1_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("t1_total", got_q[0], 24);
        chk("t1_latency", last_pop_cyc - last_acc_cyc, 5);

        // table of single-beat frames
        for (int i = 0; i < 8; i++) begin
            got_q.delete();
            got_ovf_q.delete();
            send(tbl[i].d, tbl[i].m, 1'b1);
            drain(20);
            chk("tbl_count", got_q.size(), 1);
            if (got_q.size() > 0) begin
                chk("tbl_total", got_q[0], tbl[i].exp_total);
                chk("tbl_ovf", got_ovf_q[0], 0);
            end
        end

        // three-beat frame with mixed modes
        got_q.delete();
        send(24'h000001, 1'b0, 1'b0);
        send(24'h0000FF, 1'b0, 1'b0);
        send(24'h000000, 1'b1, 1'b1);
        drain(20);
        chk("mix_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("mix_total", got_q[0], 33);

        // overlong frame saturates, next frame is clean
        got_q.delete();
        got_ovf_q.delete();
        for (int i = 0; i < 6; i++) send(24'hFFFFFF, 1'b0, i == 5);
        send(24'h00000F, 1'b0, 1'b1);
        drain(30);
        chk("sat_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("sat_total", got_q[0], 127);
            chk("sat_ovf", got_ovf_q[0], 1);
            chk("post_total", got_q[1], 4);
            chk("post_ovf", got_ovf_q[1], 0);
        end

        // streaming with downstream stalled for 10 cycles
        got_q.delete();
        idx = 0;
        saw_low = 0;
        for (int t = 0; t < 200 && (idx < 8 || exp_q.size() > 0); t++) begin
            dv = (idx < 8) ? tbl[idx].d : '0;
            step(idx < 8, dv, (idx < 8) ? tbl[idx].m : 1'b0, 1'b1, t >= 10, a);
            if (!data_ready_o) saw_low = 1;
            if (a) idx++;
        end
        chk("stall_sent", idx, 8);
        chk("stall_ready_low", saw_low, 1);
        chk("stall_count", got_q.size(), 8);
        if (got_q.size() == 8)
            for (int i = 0; i < 8; i++) chk("stall_order", got_q[i], tbl[i].exp_total);
        drain(20);

        // reset mid-frame discards the partial sum
        got_q.delete();
        send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b0);
        do_reset();
        send(24'h000003, 1'b0, 1'b1);
        drain(20);
        chk("rst_mid_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("rst_mid_total", got_q[0], 2);

        // reset while a finished total is stalled at the output
        got_q.delete();
        send(24'h0000FF, 1'b0, 1'b1);
        repeat (8) step(1'b0, '0, 1'b0, 1'b0, 1'b0, a);
        chk("stall_held_val", total_val_o, 1);
        do_reset();
        drain(20);
        chk("rst_stall_count", got_q.size(), 0);

        // random traffic against the model
        for (int t = 0; t < 800; t++) begin
            step($urandom_range(0, 9) < 7, WIDTH'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, a);
        end
        send(24'h000000, 1'b0, 1'b1);
        drain(100);
        chk("rand_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
